// File: rtl/sram_mbist_pkg.sv
// Shared types and constants for the SRAM March C- BIST controller.
package sram_mbist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_M0,
        ST_M1,
        ST_M2,
        ST_M3,
        ST_M4,
        ST_M5,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_R0,
        OP_R1,
        OP_W0,
        OP_W1
    } op_e;

    localparam int unsigned FailCntWidth = 16;

endpackage

// File: rtl/sram_mbist_cmp.sv
// Read-data compare and fail logging: sticky fail, first fail address, saturating count.
module sram_mbist_cmp
    import sram_mbist_pkg::*;
#(
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned DataWidth = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    rd_vld_i,
    input  logic                    rd_ones_i,
    input  logic [AddrWidth-1:0]    rd_addr_i,
    input  logic [DataWidth-1:0]    dout_i,
    output logic                    fail_o,
    output logic [AddrWidth-1:0]    fail_addr_o,
    output logic [FailCntWidth-1:0] fail_cnt_o
);

    logic                 vld_q;
    logic [DataWidth-1:0] exp_q;
    logic [AddrWidth-1:0] addr_q;
    logic                 miscmp;

    // The macro returns read data one cycle after the read, so compare against the registered expectation.
    assign miscmp = vld_q && (dout_i != exp_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q       <= 1'b0;
            exp_q       <= '0;
            addr_q      <= '0;
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_cnt_o  <= '0;
        end else begin
            vld_q  <= rd_vld_i;
            exp_q  <= rd_ones_i ? {DataWidth{1'b1}} : {DataWidth{1'b0}};
            addr_q <= rd_addr_i;
            if (clear_i) begin
                fail_o      <= 1'b0;
                fail_addr_o <= '0;
                fail_cnt_o  <= '0;
            end else if (miscmp) begin
                fail_o <= 1'b1;
                if (!fail_o) begin
                    fail_addr_o <= addr_q;
                end
                if (fail_cnt_o != {FailCntWidth{1'b1}}) begin
                    fail_cnt_o <= fail_cnt_o + FailCntWidth'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sram_mbist_ctrl.sv
// March C- sequencer driving the SRAM BIST port, with compare/logging in sram_mbist_cmp.
module sram_mbist_ctrl
    import sram_mbist_pkg::*;
#(
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned DataWidth = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    fail_o,
    output logic [AddrWidth-1:0]    fail_addr_o,
    output logic [FailCntWidth-1:0] fail_cnt_o,
    output logic                    bist_en_o,
    output logic                    bist_men_o,
    output logic                    bist_wen_o,
    output logic                    bist_ren_o,
    output logic [AddrWidth-1:0]    bist_addr_o,
    output logic [DataWidth-1:0]    bist_din_o,
    output logic [DataWidth-1:0]    bist_bm_o,
    input  logic [DataWidth-1:0]    bist_dout_i
);

    localparam logic [AddrWidth-1:0] AddrMax = {AddrWidth{1'b1}};

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 phase_q, phase_d;
    logic                 two_op, desc, at_end, start_ok;
    logic                 op_active;
    op_e                  op;

    assign two_op   = (state_q == ST_M1) || (state_q == ST_M2) ||
                      (state_q == ST_M3) || (state_q == ST_M4);
    assign desc     = (state_q == ST_M3) || (state_q == ST_M4);
    assign at_end   = addr_q == (desc ? {AddrWidth{1'b0}} : AddrMax);
    assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_M0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default: begin
                // Read phase first, then write phase at the same address.
                if (two_op && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (at_end) begin
                        addr_d = '0;
                        case (state_q)
                            ST_M0:   state_d = ST_M1;
                            ST_M1:   state_d = ST_M2;
                            ST_M2: begin
                                state_d = ST_M3;
                                addr_d  = AddrMax;
                            end
                            ST_M3: begin
                                state_d = ST_M4;
                                addr_d  = AddrMax;
                            end
                            ST_M4:   state_d = ST_M5;
                            default: state_d = ST_DRAIN;
                        endcase
                    end else begin
                        addr_d = desc ? addr_q - AddrWidth'(1) : addr_q + AddrWidth'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        op_active = 1'b0;
        op        = OP_R0;
        case (state_q)
            ST_M0: begin
                op_active = 1'b1;
                op        = OP_W0;
            end
            ST_M1, ST_M3: begin
                op_active = 1'b1;
                op        = phase_q ? OP_W1 : OP_R0;
            end
            ST_M2, ST_M4: begin
                op_active = 1'b1;
                op        = phase_q ? OP_W0 : OP_R1;
            end
            ST_M5: begin
                op_active = 1'b1;
                op        = OP_R0;
            end
            default: ;
        endcase
        busy_o      = op_active || (state_q == ST_DRAIN);
        done_o      = (state_q == ST_DONE);
        bist_en_o   = busy_o;
        bist_men_o  = op_active;
        bist_wen_o  = op_active && ((op == OP_W0) || (op == OP_W1));
        bist_ren_o  = op_active && ((op == OP_R0) || (op == OP_R1));
        bist_addr_o = op_active ? addr_q : '0;
        bist_bm_o   = op_active ? {DataWidth{1'b1}} : {DataWidth{1'b0}};
        bist_din_o  = (op_active && (op == OP_W1)) ? {DataWidth{1'b1}} : {DataWidth{1'b0}};
    end

    sram_mbist_cmp #(
        .AddrWidth(AddrWidth),
        .DataWidth(DataWidth)
    ) u_cmp (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (start_ok),
        .rd_vld_i   (bist_ren_o),
        .rd_ones_i  (op == OP_R1),
        .rd_addr_i  (addr_q),
        .dout_i     (bist_dout_i),
        .fail_o     (fail_o),
        .fail_addr_o(fail_addr_o),
        .fail_cnt_o (fail_cnt_o)
    );

endmodule

// File: tb/tb_sram_mbist_ctrl.sv
// Bench for sram_mbist_ctrl: 1-cycle SRAM model with stuck-at faults and a March C- reference model.
module tb_sram_mbist_ctrl;
    localparam int AW   = 6;
    localparam int DW   = 64;
    localparam int N    = 1 << AW;
    localparam int NOPS = 10 * N;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, fail_o;
    logic [AW-1:0] fail_addr_o;
    logic [15:0]   fail_cnt_o;
    logic          bist_en_o, bist_men_o, bist_wen_o, bist_ren_o;
    logic [AW-1:0] bist_addr_o;
    logic [DW-1:0] bist_din_o, bist_bm_o;
    logic [DW-1:0] bist_dout_i = '0;

    sram_mbist_ctrl #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
        .fail_addr_o(fail_addr_o), .fail_cnt_o(fail_cnt_o),
        .bist_en_o(bist_en_o), .bist_men_o(bist_men_o),
        .bist_wen_o(bist_wen_o), .bist_ren_o(bist_ren_o),
        .bist_addr_o(bist_addr_o), .bist_din_o(bist_din_o),
        .bist_bm_o(bist_bm_o), .bist_dout_i(bist_dout_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // March C- operation list: kind 0=r0 1=r1 2=w0 3=w1
    int op_kind [NOPS];
    int op_addr [NOPS];

    task automatic build_ops();
        int k = 0;
        for (int a = 0; a < N; a++) begin op_kind[k] = 2; op_addr[k] = a; k++; end
        for (int a = 0; a < N; a++) begin
            op_kind[k] = 0; op_addr[k] = a; k++; op_kind[k] = 3; op_addr[k] = a; k++;
        end
        for (int a = 0; a < N; a++) begin
            op_kind[k] = 1; op_addr[k] = a; k++; op_kind[k] = 2; op_addr[k] = a; k++;
        end
        for (int a = N - 1; a >= 0; a--) begin
            op_kind[k] = 0; op_addr[k] = a; k++; op_kind[k] = 3; op_addr[k] = a; k++;
        end
        for (int a = N - 1; a >= 0; a--) begin
            op_kind[k] = 1; op_addr[k] = a; k++; op_kind[k] = 2; op_addr[k] = a; k++;
        end
        for (int a = 0; a < N; a++) begin op_kind[k] = 0; op_addr[k] = a; k++; end
    endtask

    // Fault injection: stuck-at-1 / stuck-at-0 bit masks at one address
    int            fault_addr = -1;
    logic [DW-1:0] s1 = '0, s0 = '0;
    logic [DW-1:0] mem [N];

    function automatic bit rd_fails(int k);
        if (op_addr[k] != fault_addr) return 1'b0;
        if (op_kind[k] == 0) return s1 != '0;
        if (op_kind[k] == 1) return s0 != '0;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (bist_men_o && bist_ren_o) begin
            if (int'(bist_addr_o) == fault_addr) bist_dout_i <= (mem[bist_addr_o] | s1) & ~s0;
            else bist_dout_i <= mem[bist_addr_o];
        end
        if (bist_men_o && bist_wen_o)
            mem[bist_addr_o] <= (bist_din_o & bist_bm_o) | (mem[bist_addr_o] & ~bist_bm_o);
    end

    // Reference model state, advanced on each clock from the bench-driven inputs
    bit            model_ok = 0, m_run = 0, m_done = 0, m_fail = 0, pend = 0;
    int            rc = 0;
    int            pend_addr = 0, m_faddr = 0;
    int            m_cnt = 0;
    int            busy_cycles = 0;

    always @(posedge clk) begin
        if (rst_i) begin
            model_ok = 1; m_run = 0; m_done = 0; rc = 0;
            m_fail = 0; m_faddr = 0; m_cnt = 0; pend = 0;
        end else if (model_ok) begin
            if (pend) begin
                if (!m_fail) m_faddr = pend_addr;
                m_fail = 1;
                if (m_cnt != 16'hFFFF) m_cnt++;
            end
            pend = 0;
            if (m_run && rc < NOPS) begin
                pend = rd_fails(rc);
                pend_addr = op_addr[rc];
            end
            if (m_run) begin
                if (rc == NOPS) begin m_run = 0; m_done = 1; end
                else rc++;
            end else if (start_i) begin
                m_run = 1; m_done = 0; rc = 0;
                m_fail = 0; m_faddr = 0; m_cnt = 0;
            end
        end
    end

    logic          tr_ren0, tr_wen1, tr_ren2, tr_renl;
    logic [AW-1:0] tr_a0, tr_a1, tr_a2, tr_al;

    always @(negedge clk) begin : compare
        int kind;
        if (model_ok) begin
            if (m_run && rc == 0) busy_cycles = 0;
            if (busy_o) busy_cycles++;
            chk("busy", busy_o, m_run);
            chk("done", done_o, m_done);
            chk("fail", fail_o, m_fail);
            chk("fail_addr", fail_addr_o, m_faddr);
            chk("fail_cnt", fail_cnt_o, m_cnt);
            if (m_run && rc < NOPS) begin
                kind = op_kind[rc];
                chk("en", bist_en_o, 1);
                chk("men", bist_men_o, 1);
                chk("wen", bist_wen_o, kind >= 2);
                chk("ren", bist_ren_o, kind < 2);
                chk("addr", bist_addr_o, op_addr[rc]);
                chk("bm", bist_bm_o, ONES);
                if (kind >= 2) chk("din", bist_din_o, (kind == 3) ? ONES : '0);
                if (rc == 5 * N)     begin tr_ren0 = bist_ren_o; tr_a0 = bist_addr_o; end
                if (rc == 5 * N + 1) begin tr_wen1 = bist_wen_o; tr_a1 = bist_addr_o; end
                if (rc == 5 * N + 2) begin tr_ren2 = bist_ren_o; tr_a2 = bist_addr_o; end
                if (rc == NOPS - 1)  begin tr_renl = bist_ren_o; tr_al = bist_addr_o; end
            end else if (m_run) begin
                chk("drain_en", bist_en_o, 1);
                chk("drain_men", bist_men_o, 0);
                chk("drain_wen", bist_wen_o, 0);
                chk("drain_ren", bist_ren_o, 0);
            end else begin
                chk("idle_en", bist_en_o, 0);
                chk("idle_men", bist_men_o, 0);
                chk("idle_wen", bist_wen_o, 0);
                chk("idle_ren", bist_ren_o, 0);
                chk("idle_addr", bist_addr_o, 0);
                chk("idle_din", bist_din_o, 0);
                chk("idle_bm", bist_bm_o, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_test(input int fa, input logic [DW-1:0] f1, input logic [DW-1:0] f0,
                            input int hlo, input int hhi, input int rst_at);
        bit got_done = 0;
        fault_addr = fa; s1 = f1; s0 = f0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("start_clr_fail", fail_o, 0);
        chk("start_clr_addr", fail_addr_o, 0);
        chk("start_clr_cnt", fail_cnt_o, 0);
        chk("start_busy", busy_o, 1);
        for (int c = 0; c < 800; c++) begin
            start_i = (c >= hlo && c <= hhi);
            rst_i   = (c == rst_at);
            tick();
            if (rst_i) begin
                rst_i = 1'b0;
                start_i = 1'b0;
                return;
            end
            if (done_o) begin got_done = 1; break; end
        end
        start_i = 1'b0;
        chk("run_reached_done", got_done, 1);
        if (got_done) chk("busy_len", busy_cycles, 641);
    endtask

    initial begin
        int exp_n;
        build_ops();
        for (int a = 0; a < N; a++) mem[a] = {$urandom, $urandom};

        // Pin the reference sequence itself
        chk("model_m3_r_addr", op_addr[5 * N], 'h3F);
        chk("model_m3_w_addr", op_addr[5 * N + 1], 'h3F);
        chk("model_m3_r2_addr", op_addr[5 * N + 2], 'h3E);
        chk("model_last_addr", op_addr[NOPS - 1], 'h3F);
        fault_addr = 'h2A; s1 = 64'h20; s0 = '0;
        exp_n = 0;
        for (int k = 0; k < NOPS; k++) exp_n += rd_fails(k);
        chk("model_fault_cnt", exp_n, 3);
        fault_addr = -1; s1 = '0;

        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_fail", fail_o, 0);
        chk("reset_en", bist_en_o, 0);

        // Clean run plus address trace
        run_test(-1, '0, '0, -1, -1, -1);
        chk("clean_done", done_o, 1);
        chk("clean_fail", fail_o, 0);
        chk("clean_cnt", fail_cnt_o, 0);
        chk("trace_m3_ren", tr_ren0, 1);
        chk("trace_m3_a0", tr_a0, 'h3F);
        chk("trace_m3_wen", tr_wen1, 1);
        chk("trace_m3_a1", tr_a1, 'h3F);
        chk("trace_m3_ren2", tr_ren2, 1);
        chk("trace_m3_a2", tr_a2, 'h3E);
        chk("trace_m5_ren", tr_renl, 1);
        chk("trace_m5_a", tr_al, 'h3F);

        // Bit 5 stuck-at-1 at 0x2A
        run_test('h2A, 64'h20, '0, -1, -1, -1);
        chk("sa1_fail", fail_o, 1);
        chk("sa1_addr", fail_addr_o, 'h2A);
        chk("sa1_cnt", fail_cnt_o, 3);

        // Restart from DONE with the fault removed
        run_test(-1, '0, '0, -1, -1, -1);
        chk("rerun_done", done_o, 1);
        chk("rerun_fail", fail_o, 0);

        // start_i held mid-run must not restart
        run_test(-1, '0, '0, 10, 20, -1);
        chk("hold_done", done_o, 1);

        // Reset mid-test
        run_test('h11, 64'h1, '0, -1, -1, 100);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_fail", fail_o, 0);
        chk("midrst_cnt", fail_cnt_o, 0);
        chk("midrst_en", bist_en_o, 0);
        chk("midrst_men", bist_men_o, 0);
        tick();
        run_test(-1, '0, '0, -1, -1, -1);
        chk("post_rst_done", done_o, 1);
        chk("post_rst_fail", fail_o, 0);

        // Randomized fault location and type
        for (int i = 0; i < 6; i++) begin
            int fa, b, ty;
            logic [DW-1:0] m1, m0;
            fa = $urandom_range(N - 1);
            b  = $urandom_range(DW - 1);
            ty = $urandom_range(3);
            m1 = (ty == 1 || ty == 3) ? (64'h1 << b) : '0;
            m0 = (ty == 2 || ty == 3) ? (64'h1 << ((b + 1) % DW)) : '0;
            run_test(fa, m1, m0, -1, -1, -1);
            exp_n = 3 * (m1 != '0) + 2 * (m0 != '0);
            chk("rnd_fail", fail_o, exp_n != 0);
            chk("rnd_cnt", fail_cnt_o, exp_n);
            chk("rnd_addr", fail_addr_o, (exp_n != 0) ? fa : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sram_mbist_ctrl.md
SRAM_MBIST_CTRL -- requirements
Module: sram_mbist_ctrl

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 8, meaning SRAM macro address bits; the word count is N = 2^AddrWidth.
REQ-002 The block SHALL have parameter DataWidth, default 64, meaning SRAM macro data and bit-mask width.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, shared with the macro A_CLK.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: test start request, sampled only in IDLE or DONE.
REQ-006 The block SHALL have ports busy_o, done_o and fail_o, each output, 1 bit: test running, test finished, at least one miscompare.
REQ-007 The block SHALL have port fail_addr_o, output, AddrWidth bits: address of the first miscompare.
REQ-008 The block SHALL have port fail_cnt_o, output, 16 bits: saturating miscompare count.
REQ-009 The block SHALL have ports bist_en_o, bist_men_o, bist_wen_o and bist_ren_o, each output, 1 bit: they drive the macro A_BIST_EN, A_BIST_MEN, A_BIST_WEN and A_BIST_REN.
REQ-010 The block SHALL have ports bist_addr_o (AddrWidth), bist_din_o (DataWidth) and bist_bm_o (DataWidth), all outputs: they drive the macro A_BIST_ADDR, A_BIST_DIN and A_BIST_BM.
REQ-011 The block SHALL have port bist_dout_i, input, DataWidth bits: the macro A_DOUT.

Function
REQ-012 The block SHALL run March C- using the FSM states IDLE, M0, M1, M2, M3, M4, M5, DRAIN and DONE.
REQ-013 The march elements SHALL be: M0 ascending (w0); M1 ascending (r0, w1); M2 ascending (r1, w0); M3 descending (r0, w1); M4 descending (r1, w0); M5 ascending (r0).
REQ-014 Each operation SHALL take exactly one cycle; a two-operation element issues the read at address A, then the write at A in the next cycle, then advances the address.
REQ-015 Ascending elements SHALL start at address 0 and end at N-1; descending elements SHALL start at N-1 and end at 0; the transition to the next element occurs after the last operation at the terminal address, with no idle cycle.
REQ-016 In IDLE and DONE, start_i=1 SHALL enter M0 in the next cycle; the first operation is issued in that cycle.
REQ-017 start_i SHALL be ignored in M0..M5 and DRAIN.
REQ-018 After the last M5 read, the FSM SHALL spend one DRAIN cycle, for read-data latency, then enter DONE.
REQ-019 busy_o SHALL be 1 exactly in M0..DRAIN, i.e. for 10N+1 cycles.
REQ-020 done_o SHALL be 1 exactly in DONE and remain there until start_i or reset.
REQ-021 During an operation: bist_en_o=1 and bist_men_o=1; bist_wen_o=1 on writes and bist_ren_o=1 on reads (mutually exclusive); bist_bm_o SHALL be all-ones; bist_din_o SHALL be all-zeros for w0 and all-ones for w1.
REQ-022 bist_en_o SHALL remain 1 during DRAIN with men, wen and ren at 0.
REQ-023 Outside M0..DRAIN, all bist_* outputs SHALL be 0.
REQ-024 Read data SHALL be compared in the cycle after its read is issued, against a registered expected value (all-0 for r0, all-1 for r1) and a registered compare-valid flag.
REQ-025 On a miscompare, fail_o and the count update SHALL be visible one cycle later: fail_o is sticky and fail_cnt_o increments, saturating at 0xFFFF.
REQ-026 fail_addr_o SHALL load the failing read's address only on the first miscompare of a run.
REQ-027 Accepting start_i SHALL clear fail_o, fail_addr_o and fail_cnt_o in the same cycle M0 is entered.
REQ-028 A miscompare on the final M5 read SHALL be detected in DRAIN and reported in the DONE cycle.

Reset
REQ-029 rst_i=1 at any clock edge, including mid-test, SHALL return the FSM to IDLE.
REQ-030 After reset, every output SHALL be 0 from the following cycle.
REQ-031 Reset SHALL clear the compare-valid flag, so no pending miscompare is logged after reset.

Structure
REQ-032 A shared package sram_mbist_pkg SHALL hold the FSM state enum, the op type {OP_R0, OP_R1, OP_W0, OP_W1}, and the fail-counter width constant (16).
REQ-033 Compare and fail logging (expected register, valid flag, sticky fail, first address, saturating counter) SHALL be the sub-module sram_mbist_cmp.
REQ-034 The sequencer (FSM, address counter with up/down direction, op phase bit) SHALL reside in the top module.

Verification (AddrWidth=6, DataWidth=64, behavioural 1-cycle SRAM model)
REQ-035 Fault-free model: start_i pulse in IDLE -> busy_o=1 for 641 cycles, then done_o=1, fail_o=0, fail_cnt_o=0.
REQ-036 Bit 5 stuck-at-1 at address 0x2A -> fail_o=1, fail_addr_o=0x2A, fail_cnt_o=3 (failures in M1, M3, M5).
REQ-037 Address trace check -> the first M3 access is a read at 0x3F, then a write at 0x3F, then a read at 0x3E; the last M5 access is a read at 0x3F with bist_ren_o=1.
REQ-038 start_i held at 1 during run cycles 10..20 -> run length remains 641 cycles and no restart occurs.
REQ-039 rst_i asserted for 1 cycle at run cycle 100 -> all outputs 0 the next cycle, FSM in IDLE, and a later start runs a full clean test.
REQ-040 Faulty run followed by start_i in DONE with the fault removed -> fail_o, fail_addr_o and fail_cnt_o cleared to 0, and the second run ends with done_o=1 and fail_o=0.
